// File: rtl/lcd_spi_burst_writer.sv
// Buffered LCD SPI writer: a FIFO of {w16,dc,payload} entries serialised to the
// panel in SPI mode 0, MSB first, with CS held low across back-to-back words.
module lcd_spi_burst_writer #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CS_HOLD    = 4
) (
    input  logic                          sys_clk_50MHz,
    input  logic                          sys_rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [16:0]                   in_data,
    input  logic                          in_w16,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          wr_done,
    output logic                          lcd_cs,
    output logic                          lcd_dc,
    output logic                          lcd_sclk,
    output logic                          lcd_mosi
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_ZERO   = DIV_W'(0);
    localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(CS_HOLD - 1);
    localparam logic [AW-1:0]     PTR_ZERO   = AW'(0);
    localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
    localparam logic [AW:0]       LEVEL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]       LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [17:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic [17:0]       head_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_empty_s;

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              load_go_s;
    logic              tick_s;
    logic              word_end_s;
    logic [DIV_W-1:0]  div_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [3:0]        bit_r;
    logic [15:0]       shreg_r;
    logic              cs_r;
    logic              dc_r;
    logic              sclk_r;
    logic              mosi_r;
    logic              wr_done_r;
    logic              busy_r;

    assign in_ready     = (level_r < LEVEL_FULL);
    assign fifo_level   = level_r;
    assign fifo_empty_s = (level_r == LEVEL_ZERO);
    assign push_s       = in_valid & in_ready;
    assign pop_s        = load_go_s;
    assign head_s       = mem_r[rd_ptr_r];

    assign tick_s     = (div_r == DIV_LAST);
    assign word_end_s = tick_s & sclk_r & (bit_r == 4'd0);
    assign load_go_s  = (state_nx_s == LOAD);

    assign lcd_cs   = cs_r;
    assign lcd_dc   = dc_r;
    assign lcd_sclk = sclk_r;
    assign lcd_mosi = mosi_r;
    assign wr_done  = wr_done_r;
    assign busy     = busy_r;

    // FIFO storage; contents need no reset because level gates every read
    always_ff @(posedge sys_clk_50MHz) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_w16, in_data};
        end
    end

    // FIFO pointers and level
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Next-state logic; a finished word always passes through HOLD for one
    // cycle, which provides the extra cycle between back-to-back words
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) state_nx_s = LOAD;
                else               state_nx_s = IDLE;
            end
            LOAD: begin
                state_nx_s = SHIFT;
            end
            SHIFT: begin
                if (word_end_s) state_nx_s = HOLD;
                else            state_nx_s = SHIFT;
            end
            HOLD: begin
                if (!fifo_empty_s)                  state_nx_s = LOAD;
                else if (hold_cnt_r == HOLD_LAST)   state_nx_s = IDLE;
                else                                state_nx_s = HOLD;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Serialiser: the LOAD cycle doubles as the first low-phase cycle of the MSB
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            wr_done_r  <= 1'b0;
            hold_cnt_r <= HOLD_ZERO;
            div_r      <= DIV_ZERO;
            bit_r      <= 4'd0;
            shreg_r    <= 16'h0000;
            cs_r       <= 1'b1;
            dc_r       <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            busy_r     <= (state_nx_s != IDLE);
            wr_done_r  <= (state_r == SHIFT) && word_end_s;
            hold_cnt_r <= (state_r == HOLD) ? (hold_cnt_r + HOLD_ONE) : HOLD_ZERO;
            if (load_go_s) begin
                cs_r    <= 1'b0;
                dc_r    <= head_s[16];
                sclk_r  <= 1'b0;
                shreg_r <= head_s[15:0];
                bit_r   <= head_s[17] ? 4'd15 : 4'd7;
                mosi_r  <= head_s[17] ? head_s[15] : head_s[7];
                div_r   <= DIV_ZERO;
            end else if ((state_r == LOAD) || (state_r == SHIFT)) begin
                if (tick_s) begin
                    div_r <= DIV_ZERO;
                    if (!sclk_r) begin
                        sclk_r <= 1'b1;
                    end else begin
                        sclk_r <= 1'b0;
                        if (bit_r != 4'd0) begin
                            bit_r  <= bit_r - 4'd1;
                            mosi_r <= shreg_r[bit_r - 4'd1];
                        end
                    end
                end else begin
                    div_r <= div_r + DIV_ONE;
                end
            end else if (state_nx_s == IDLE) begin
                cs_r <= 1'b1;
            end
        end
    end

endmodule
